adder_bist: RTL and testbench

Built-in self-test driver and checker for the registered dual-adder wrapper (Brent-Kung and ripple-carry paths sharing one operand set). It drives the wrapper's `ina`/`inb`/`cin`, and consumes `outbk`/`coutbk`/`outrc`/`coutrc`. An internal golden sum is delayed to match the wrapper's pipeline latency, and the block compares each adder path against it independently. It sits beside the adder wrapper in the test harness and in the on-chip self-test path, and reports per-path error counts and a pass/fail verdict.

---
 rtl/adder_pkg.sv | 25 ++
 rtl/adder_bist_if.sv | 22 ++
 rtl/adder_bist_lfsr64.sv | 28 ++
 rtl/adder_bist.sv | 226 ++++++++++++++++++++++
 tb/tb_adder_bist.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the dual-adder self-test: FSM states,
// directed operand patterns and the 64-bit LFSR tap mask.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int          NUM_DIRECTED = 4;
  localparam logic [63:0] DIR_ZERO     = 64'h0000_0000_0000_0000;
  localparam logic [63:0] DIR_ONES     = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] DIR_ALT_A    = 64'h5555_5555_5555_5555;
  localparam logic [63:0] DIR_ALT_B    = 64'hAAAA_AAAA_AAAA_AAAA;

  // Taps 64,63,61,60 (1-based) -> bit indices 63,62,60,59
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/adder_bist_if.sv
// Operand/result bundle between the self-test block and the dual-adder wrapper.
interface adder_bist_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] ina;
  logic [WIDTH-1:0] inb;
  logic             cin;
  logic [WIDTH-1:0] outbk;
  logic             coutbk;
  logic [WIDTH-1:0] outrc;
  logic             coutrc;

  modport master (
    output ina, inb, cin,
    input  outbk, coutbk, outrc, coutrc
  );

  modport slave (
    input  ina, inb, cin,
    output outbk, coutbk, outrc, coutrc
  );
endinterface

// File: rtl/adder_bist_lfsr64.sv
// 64-bit Fibonacci LFSR with synchronous reload to the seed and step enable.
module lfsr64
  import adder_pkg::*;
#(
  parameter logic [63:0] SEED = 64'h0123_4567_89AB_CDEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        enable,
  output logic [63:0] state
);

  logic [63:0] state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SEED;
    end else if (load) begin
      state_reg <= SEED;
    end else if (enable) begin
      state_reg <= lfsr_step(state_reg);
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/adder_bist.sv
// Self-test driver/checker for the registered Brent-Kung / ripple-carry wrapper:
// drives directed then LFSR vectors and checks both paths against a delayed golden sum.
module adder_bist
  import adder_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          LATENCY     = 2,
  parameter int          NUM_VECTORS = 1024,
  parameter logic [63:0] SEED        = 64'h0123_4567_89AB_CDEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  adder_bist_if.master bus,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  err_bk,
  output logic [15:0]  err_rc,
  output logic [15:0]  first_err_idx
);

  localparam logic [15:0] NVEC    = 16'(NUM_VECTORS);
  localparam int          DW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [15:0] NO_ERR  = 16'hFFFF;

  state_t           state_reg, state_next;
  logic [15:0]      idx_reg, idx_next;
  logic [DW-1:0]    drain_reg, drain_next;

  logic             drive;
  logic [15:0]      drive_k;
  logic             clear;
  logic             lfsr_load;
  logic             lfsr_en;
  logic [63:0]      lfsr_state;

  logic [WIDTH-1:0] vec_a, vec_b;
  logic             vec_c;

  logic [WIDTH-1:0] ina_reg, inb_reg;
  logic             cin_reg;
  logic             drv_valid_reg;
  logic [15:0]      drv_idx_reg;

  logic [WIDTH:0]   exp_now;
  logic [WIDTH:0]   exp_pipe   [LATENCY];
  logic [15:0]      idx_pipe   [LATENCY];
  logic [LATENCY-1:0] valid_pipe;

  logic             mis_bk, mis_rc;
  logic [15:0]      err_bk_reg, err_rc_reg, first_err_reg;

  lfsr64 #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (lfsr_load),
    .enable (lfsr_en),
    .state  (lfsr_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      drain_reg <= drain_next;
    end
  end

  // idx_reg holds the index of the next vector to put on the bus
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    drain_next = drain_reg;
    drive      = 1'b0;
    drive_k    = idx_reg;
    clear      = 1'b0;
    lfsr_load  = 1'b0;
    lfsr_en    = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_RUN;
          clear      = 1'b1;
          lfsr_load  = 1'b1;
          drive      = 1'b1;
          drive_k    = '0;
          idx_next   = 16'd1;
        end
      end
      ST_RUN: begin
        if (idx_reg == NVEC) begin
          state_next = ST_DRAIN;
          drain_next = '0;
        end else begin
          drive    = 1'b1;
          idx_next = idx_reg + 16'd1;
          lfsr_en  = (idx_reg >= 16'(NUM_DIRECTED));
        end
      end
      ST_DRAIN: begin
        if (drain_reg == DW'(LATENCY - 1)) begin
          state_next = ST_DONE;
        end else begin
          drain_next = drain_reg + DW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    vec_a = '0;
    vec_b = '0;
    vec_c = 1'b0;
    if (drive) begin
      case (drive_k)
        16'd0: begin
          vec_a = WIDTH'(DIR_ZERO);
          vec_b = WIDTH'(DIR_ZERO);
          vec_c = 1'b0;
        end
        16'd1: begin
          vec_a = WIDTH'(DIR_ONES);
          vec_b = WIDTH'(DIR_ZERO);
          vec_c = 1'b1;
        end
        16'd2: begin
          vec_a = WIDTH'(DIR_ONES);
          vec_b = WIDTH'(DIR_ONES);
          vec_c = 1'b1;
        end
        16'd3: begin
          vec_a = WIDTH'(DIR_ALT_A);
          vec_b = WIDTH'(DIR_ALT_B);
          vec_c = 1'b1;
        end
        default: begin
          vec_a = WIDTH'(lfsr_state[63:32]);
          vec_b = WIDTH'(lfsr_state[31:0]);
          vec_c = ^lfsr_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ina_reg       <= '0;
      inb_reg       <= '0;
      cin_reg       <= 1'b0;
      drv_valid_reg <= 1'b0;
      drv_idx_reg   <= '0;
    end else begin
      ina_reg       <= vec_a;
      inb_reg       <= vec_b;
      cin_reg       <= vec_c;
      drv_valid_reg <= drive;
      drv_idx_reg   <= drive_k;
    end
  end

  assign bus.ina = ina_reg;
  assign bus.inb = inb_reg;
  assign bus.cin = cin_reg;

  assign exp_now = {1'b0, ina_reg} + {1'b0, inb_reg} + {{WIDTH{1'b0}}, cin_reg};

  // Golden sum follows the wrapper's input and output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_pipe <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        exp_pipe[i] <= '0;
        idx_pipe[i] <= '0;
      end
    end else begin
      valid_pipe[0] <= drv_valid_reg;
      exp_pipe[0]   <= exp_now;
      idx_pipe[0]   <= drv_idx_reg;
      for (int i = 1; i < LATENCY; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        exp_pipe[i]   <= exp_pipe[i-1];
        idx_pipe[i]   <= idx_pipe[i-1];
      end
    end
  end

  assign mis_bk = valid_pipe[LATENCY-1] && ({bus.coutbk, bus.outbk} != exp_pipe[LATENCY-1]);
  assign mis_rc = valid_pipe[LATENCY-1] && ({bus.coutrc, bus.outrc} != exp_pipe[LATENCY-1]);

  // 16'hFFFF doubles as the "no error yet" marker; vector indices never reach it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_bk_reg    <= '0;
      err_rc_reg    <= '0;
      first_err_reg <= NO_ERR;
    end else if (clear) begin
      err_bk_reg    <= '0;
      err_rc_reg    <= '0;
      first_err_reg <= NO_ERR;
    end else begin
      if (mis_bk && (err_bk_reg != 16'hFFFF)) begin
        err_bk_reg <= err_bk_reg + 16'd1;
      end
      if (mis_rc && (err_rc_reg != 16'hFFFF)) begin
        err_rc_reg <= err_rc_reg + 16'd1;
      end
      if ((mis_bk || mis_rc) && (first_err_reg == NO_ERR)) begin
        first_err_reg <= idx_pipe[LATENCY-1];
      end
    end
  end

  assign busy          = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign done          = (state_reg == ST_DONE);
  assign pass          = done && (err_bk_reg == 16'd0) && (err_rc_reg == 16'd0);
  assign err_bk        = err_bk_reg;
  assign err_rc        = err_rc_reg;
  assign first_err_idx = first_err_reg;

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: behavioural wrapper with injectable faults, directed table,
// randomized fault triggers against a vector/verdict model, reset, restart and saturation.
module tb_adder_bist;

  localparam int          W    = 32;
  localparam int          L    = 2;
  localparam int          N    = 8;
  localparam int          NS   = 65535;
  localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_sat = 1'b0;

  always #5 clk = ~clk;

  adder_bist_if #(.WIDTH(W)) bus ();
  adder_bist_if #(.WIDTH(W)) bus_sat ();

  logic        busy, done, pass;
  logic [15:0] err_bk, err_rc, first_err_idx;
  logic        busy_s, done_s, pass_s;
  logic [15:0] err_bk_s, err_rc_s, first_s;

  adder_bist #(.WIDTH(W), .LATENCY(L), .NUM_VECTORS(N), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .pass(pass),
    .err_bk(err_bk), .err_rc(err_rc), .first_err_idx(first_err_idx)
  );

  adder_bist #(.WIDTH(W), .LATENCY(L), .NUM_VECTORS(NS), .SEED(SEED)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_sat), .bus(bus_sat),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_bk(err_bk_s), .err_rc(err_rc_s), .first_err_idx(first_s)
  );

  // ---------------- behavioural wrapper (2 flops) with fault injection
  int           fault_mode = 0;   // 0 ideal, 1 coutbk stuck 0, 2 triggered bit flips
  logic [3:0]   trig_bk = 4'd0, trig_rc = 4'd0;
  logic [W:0]   flip_bk = '0, flip_rc = '0;
  logic [W-1:0] wa = '0, wb = '0;
  logic         wc = 1'b0;
  logic [W:0]   sum_q = '0;
  logic         hit_bk_q = 1'b0, hit_rc_q = 1'b0;
  logic [W:0]   bk_val, rc_val;

  always @(posedge clk) begin
    wa       <= bus.ina;
    wb       <= bus.inb;
    wc       <= bus.cin;
    sum_q    <= {1'b0, wa} + {1'b0, wb} + {{W{1'b0}}, wc};
    hit_bk_q <= (fault_mode == 2) && (wa[3:0] == trig_bk);
    hit_rc_q <= (fault_mode == 2) && (wb[3:0] == trig_rc);
  end

  always_comb begin
    bk_val = hit_bk_q ? (sum_q ^ flip_bk) : sum_q;
    if (fault_mode == 1) bk_val[W] = 1'b0;
    rc_val = hit_rc_q ? (sum_q ^ flip_rc) : sum_q;
  end

  assign bus.outbk  = bk_val[W-1:0];
  assign bus.coutbk = bk_val[W];
  assign bus.outrc  = rc_val[W-1:0];
  assign bus.coutrc = rc_val[W];

  // Saturation wrapper: ripple path always inverted
  logic [W-1:0] sa = '0, sb = '0;
  logic         sc = 1'b0;
  logic [W:0]   ssum = '0;
  always @(posedge clk) begin
    sa   <= bus_sat.ina;
    sb   <= bus_sat.inb;
    sc   <= bus_sat.cin;
    ssum <= {1'b0, sa} + {1'b0, sb} + {{W{1'b0}}, sc};
  end
  assign bus_sat.outbk  = ssum[W-1:0];
  assign bus_sat.coutbk = ssum[W];
  assign bus_sat.outrc  = ~ssum[W-1:0];
  assign bus_sat.coutrc = ~ssum[W];

  // ---------------- reference model
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W:0]   sum;
  } vec_t;

  vec_t         dir_tab [4];
  logic [W-1:0] ref_a [N];
  logic [W-1:0] ref_b [N];
  logic         ref_c [N];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_ref();
    logic [63:0] s;
    s = SEED;
    for (int k = 0; k < N; k++) begin
      if (k < 4) begin
        ref_a[k] = dir_tab[k].a;
        ref_b[k] = dir_tab[k].b;
        ref_c[k] = dir_tab[k].c;
      end else begin
        ref_a[k] = s[63:32];
        ref_b[k] = s[31:0];
        ref_c[k] = ^s;
        s = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
      end
    end
  endtask

  task automatic predict(output int e_bk, output int e_rc, output logic [15:0] first);
    logic [W:0] sum;
    logic       bad_bk, bad_rc;
    e_bk  = 0;
    e_rc  = 0;
    first = 16'hFFFF;
    for (int k = 0; k < N; k++) begin
      sum    = {1'b0, ref_a[k]} + {1'b0, ref_b[k]} + {{W{1'b0}}, ref_c[k]};
      bad_bk = ((fault_mode == 1) && sum[W]) || ((fault_mode == 2) && (ref_a[k][3:0] == trig_bk));
      bad_rc = (fault_mode == 2) && (ref_b[k][3:0] == trig_rc);
      if (bad_bk) e_bk++;
      if (bad_rc) e_rc++;
      if ((bad_bk || bad_rc) && (first == 16'hFFFF)) first = 16'(k);
    end
  endtask

  task automatic do_run(input string name);
    int         e_bk, e_rc, cyc;
    logic [15:0] e_first;
    predict(e_bk, e_rc, e_first);
    start = 1'b1;
    tick();                 // edge 0
    start = 1'b0;
    check({name, "/busy_e0"}, busy, 1'b1);
    check({name, "/done_e0"}, done, 1'b0);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s/vec%0d", name, k), {bus.ina, bus.inb, bus.cin}, {ref_a[k], ref_b[k], ref_c[k]});
      if (k < 4)
        check($sformatf("%s/dsum%0d", name, k), {1'b0, bus.ina} + {1'b0, bus.inb} + {{W{1'b0}}, bus.cin},
              dir_tab[k].sum);
      tick();
    end
    check({name, "/drain_zero"}, {bus.ina, bus.inb, bus.cin}, '0);
    check({name, "/busy_drain"}, busy, 1'b1);
    cyc = N;
    while (!done && cyc < N + L + 20) begin
      tick();
      cyc++;
    end
    check({name, "/done_edge"}, cyc, N + L);
    check({name, "/busy_done"}, busy, 1'b0);
    check({name, "/err_bk"}, err_bk, 16'(e_bk));
    check({name, "/err_rc"}, err_rc, 16'(e_rc));
    check({name, "/first"}, first_err_idx, e_first);
    check({name, "/pass"}, pass, (e_bk == 0) && (e_rc == 0));
    $display("run %s: mode=%0d err_bk=%0d err_rc=%0d first=%0h pass=%0b", name, fault_mode,
             err_bk, err_rc, first_err_idx, pass);
  endtask

  initial begin
    int cyc;

    dir_tab[0] = '{a: 32'h0000_0000, b: 32'h0000_0000, c: 1'b0, sum: 33'h0_0000_0000};
    dir_tab[1] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0000, c: 1'b1, sum: 33'h1_0000_0000};
    dir_tab[2] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, c: 1'b1, sum: 33'h1_FFFF_FFFF};
    dir_tab[3] = '{a: 32'h5555_5555, b: 32'hAAAA_AAAA, c: 1'b1, sum: 33'h1_0000_0000};
    build_ref();

    // Reset values
    tick();
    tick();
    check("rst/busy", busy, 1'b0);
    check("rst/done", done, 1'b0);
    check("rst/pass", pass, 1'b0);
    check("rst/errs", {err_bk, err_rc}, 32'h0);
    check("rst/first", first_err_idx, 16'hFFFF);
    check("rst/bus", {bus.ina, bus.inb, bus.cin}, '0);
    rst_n = 1'b1;
    tick();
    check("idle/busy", busy, 1'b0);

    // Ideal wrapper, then stuck carry-out, then restart from DONE twice
    fault_mode = 0;
    do_run("ideal");
    fault_mode = 1;
    do_run("cout_stuck");
    check("cout_stuck/first_is1", first_err_idx, 16'd1);
    do_run("restart_same");

    // Randomized triggered faults
    for (int r = 0; r < 6; r++) begin
      fault_mode = 2;
      trig_bk = 4'($urandom_range(0, 15));
      trig_rc = 4'($urandom_range(0, 15));
      flip_bk = {1'($urandom), 32'($urandom)} | 33'd1;
      flip_rc = {1'($urandom), 32'($urandom)} | 33'd2;
      do_run($sformatf("rand%0d", r));
    end

    // Reset mid-run after errors have accumulated
    fault_mode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("midrst/err_before", err_bk, 16'd2);
    rst_n = 1'b0;
    #1;
    check("midrst/busy", busy, 1'b0);
    check("midrst/done", done, 1'b0);
    check("midrst/err_bk", err_bk, 16'd0);
    check("midrst/first", first_err_idx, 16'hFFFF);
    check("midrst/bus", {bus.ina, bus.inb, bus.cin}, '0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("postrst/idle", {busy, done, err_bk, err_rc}, '0);
    fault_mode = 0;
    do_run("after_rst");

    // Saturation on the ripple path
    start_sat = 1'b1;
    tick();
    start_sat = 1'b0;
    cyc = 0;
    while (!done_s && cyc < 70000) begin
      tick();
      cyc++;
    end
    check("sat/done_edge", cyc, NS + L);
    check("sat/err_rc", err_rc_s, 16'hFFFF);
    check("sat/err_bk", err_bk_s, 16'd0);
    check("sat/first", first_s, 16'd0);
    check("sat/pass", pass_s, 1'b0);
    tick();
    check("sat/hold", err_rc_s, 16'hFFFF);
    $display("run sat: err_bk=%0d err_rc=%0h first=%0h", err_bk_s, err_rc_s, first_s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
